ecg_frame_streamer: RTL and testbench

//  Host-side initiator for the ECG transformer classifier core.

---
 rtl/ecg_frame_streamer.sv | 152 +++++++++++++++
 tb/tb_ecg_frame_streamer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_frame_streamer.sv
// ecg_frame_streamer: buffers one ECG frame from a valid/ready port,
// kicks the classifier, streams the frame, then returns the captured class.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   in_valid/in_ready  host sample write handshake, in_data sample
//   start, ecg_input   classifier kick pulse and sample stream
//   classifier         class index from the classifier
//   res_valid/res_ready result handshake, res_class captured class
//   busy               high whenever not filling the buffer
module ecg_frame_streamer #(
  parameter int DATA_WIDTH  = 8,
  parameter int N_SAMPLES   = 15,
  parameter int PAD_SLOTS   = 1,
  parameter int RESULT_WAIT = 4096,
  parameter int CLS_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  start,
  output logic [DATA_WIDTH-1:0] ecg_input,
  input  logic [CLS_WIDTH-1:0]  classifier,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CLS_WIDTH-1:0]  res_class,
  output logic                  busy
);

  localparam int SLOTS = N_SAMPLES + PAD_SLOTS;
  localparam int CW    = $clog2(SLOTS);

  localparam logic [CW-1:0] LAST_WR   = CW'(N_SAMPLES - 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(SLOTS - 1);
  localparam logic [CW-1:0] N_CNT     = CW'(N_SAMPLES);
  localparam logic [15:0]   LAST_WAIT = 16'(RESULT_WAIT - 1);

  typedef enum logic [2:0] {
    FILL,
    KICK,
    STREAM,
    WAIT,
    RESULT
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] sbuf [N_SAMPLES];

  logic [CW-1:0] wr_cnt, wr_n;
  logic [CW-1:0] idx, idx_n, idx_nx;
  logic [15:0]   wait_cnt, wait_n;

  logic                  start_n;
  logic [DATA_WIDTH-1:0] ecg_n;
  logic                  rv_n;
  logic [CLS_WIDTH-1:0]  rc_n;

  assign in_ready = (state == FILL);
  assign busy     = (state != FILL);
  assign idx_nx   = idx + 1'b1;

  // Registered outputs are computed for the cycle after this one,
  // so buf[k] appears on ecg_input k+1 cycles after the start cycle.
  always_comb begin
    state_n = state;
    wr_n    = wr_cnt;
    idx_n   = idx;
    wait_n  = wait_cnt;
    start_n = 1'b0;
    ecg_n   = '0;
    rv_n    = res_valid;
    rc_n    = res_class;
    unique case (state)
      FILL: begin
        if (in_valid) begin
          wr_n = wr_cnt + 1'b1;
          if (wr_cnt == LAST_WR) begin
            state_n = KICK;
            start_n = 1'b1;
          end
        end
      end
      KICK: begin
        state_n = STREAM;
        idx_n   = '0;
        ecg_n   = sbuf[0];
      end
      STREAM: begin
        if (idx == LAST_SLOT) begin
          state_n = WAIT;
          wait_n  = '0;
        end else begin
          idx_n = idx_nx;
          if (idx_nx < N_CNT)
            ecg_n = sbuf[idx_nx];
        end
      end
      WAIT: begin
        wait_n = wait_cnt + 16'd1;
        if (wait_cnt == LAST_WAIT) begin
          rv_n    = 1'b1;
          rc_n    = classifier;
          state_n = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          rv_n    = 1'b0;
          wr_n    = '0;
          state_n = FILL;
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      wr_cnt    <= '0;
      idx       <= '0;
      wait_cnt  <= '0;
      start     <= 1'b0;
      ecg_input <= '0;
      res_valid <= 1'b0;
      res_class <= '0;
    end else begin
      state     <= state_n;
      wr_cnt    <= wr_n;
      idx       <= idx_n;
      wait_cnt  <= wait_n;
      start     <= start_n;
      ecg_input <= ecg_n;
      res_valid <= rv_n;
      res_class <= rc_n;
    end
  end

  // Written only while filling, so the stream is the frame as accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SAMPLES; i++)
        sbuf[i] <= '0;
    end else if (state == FILL && in_valid) begin
      sbuf[wr_cnt] <= in_data;
    end
  end

endmodule

// File: tb/tb_ecg_frame_streamer.sv
// Bench for ecg_frame_streamer: frame table plus reset/abort sequences,
// stream contents checked against a scoreboard of accepted samples.
module tb_ecg_frame_streamer;

  localparam int N  = 15;
  localparam int RW = 8;

  typedef struct {
    int         base;
    int         step;
    bit         gapped;
    bit         alt;
    logic [3:0] cls;
    logic [3:0] exp_cls;
    int         hold;
    bit         abort_res;
  } frm_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       start;
  logic [7:0] ecg_input;
  logic [3:0] classifier;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_class;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int sb [$];
  frm_t tbl [5];

  always #5 clk = ~clk;

  ecg_frame_streamer #(
    .DATA_WIDTH (8),
    .N_SAMPLES  (N),
    .PAD_SLOTS  (1),
    .RESULT_WAIT(RW),
    .CLS_WIDTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .start     (start),
    .ecg_input (ecg_input),
    .classifier(classifier),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_class (res_class),
    .busy      (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sample(input frm_t f, input int k);
    logic signed [7:0] v;
    if (f.alt)
      v = (k % 2 == 0) ? 8'sh80 : 8'sh7f;
    else
      v = 8'(f.base + f.step * k);
    return int'(v);
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_ecg"}, ecg_input, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_class"}, res_class, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic send_frame(input frm_t f);
    for (int k = 0; k < N; k++) begin
      if (f.gapped) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = 8'(sample(f, k));
      sb.push_back(sample(f, k));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    @(negedge clk);
    while (!start && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_stream(input bit pulse);
    int n;
    int e;
    wait_start(n);
    chk("start_latency", n, 0);
    chk("kick_ecg", ecg_input, 0);
    chk("kick_in_ready", in_ready, 0);
    chk("kick_busy", busy, 1);
    for (int s = 0; s < N + 1; s++) begin
      @(negedge clk);
      if (s < N)
        e = (sb.size() > 0) ? sb.pop_front() : 999;
      else
        e = 0;
      chk("stream_data", int'($signed(ecg_input)), e);
      chk("stream_start", start, 0);
      if (pulse) chk("stream_in_ready", in_ready, 0);
      in_valid = pulse & s[0];
      in_data  = 8'h55;
    end
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic run_result(input frm_t f);
    int n = 0;
    int spur = 0;
    do begin
      @(negedge clk);
      n++;
      if (start) spur++;
      in_valid  = f.alt & n[0];
      res_ready = f.alt & ~n[0];
    end while (!res_valid && n < 200);
    in_valid  = 1'b0;
    res_ready = 1'b0;
    chk("res_latency", n, RW + 1);
    chk("res_class", res_class, f.exp_cls);
    chk("wait_no_start", spur, 0);
    chk("res_in_ready", in_ready, 0);
    if (f.abort_res) begin
      #2 rst = 1'b1;
      #1 chk_reset_outs("res_abort");
      @(posedge clk); #1 rst = 1'b0;
      return;
    end
    for (int h = 0; h < f.hold; h++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_class", res_class, f.exp_cls);
    end
    res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    chk("done_res_valid", res_valid, 0);
    chk("done_in_ready", in_ready, 1);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    frm_t f5;
    int n;
    int found;

    tbl[0] = '{-8,   1,  1'b0, 1'b0, 4'd3,  4'd3,  10, 1'b0};
    tbl[1] = '{10,   10, 1'b1, 1'b0, 4'd9,  4'd9,  2,  1'b0};
    tbl[2] = '{0,    0,  1'b0, 1'b1, 4'd15, 4'd15, 0,  1'b0};
    tbl[3] = '{100, -13, 1'b1, 1'b0, 4'd6,  4'd6,  1,  1'b1};
    tbl[4] = '{-1,  -9,  1'b0, 1'b0, 4'd0,  4'd0,  3,  1'b0};

    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    res_ready  = 1'b0;
    classifier = '0;

    #3 rst = 1'b1;
    #1 chk_reset_outs("por");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_busy", busy, 0);

    // Partial frame discarded by reset.
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 8'd99;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1 chk_reset_outs("partial");
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      classifier = tbl[i].cls;
      send_frame(tbl[i]);
      run_stream(tbl[i].alt);
      run_result(tbl[i]);
    end

    // Abort mid-stream while sample 7 is on ecg_input.
    f5 = '{1, 1, 1'b0, 1'b0, 4'd5, 4'd5, 1, 1'b0};
    classifier = f5.cls;
    send_frame(f5);
    wait_start(n);
    chk("abort_start_latency", n, 0);
    found = 0;
    for (int s = 0; s < 20 && found == 0; s++) begin
      @(negedge clk);
      if (ecg_input == 8'd7) found = 1;
    end
    chk("abort_found_7", found, 1);
    #2 rst = 1'b1;
    #1 chk_reset_outs("abort");
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;

    f5 = '{-50, 7, 1'b0, 1'b0, 4'd12, 4'd12, 1, 1'b0};
    classifier = f5.cls;
    send_frame(f5);
    run_stream(1'b0);
    run_result(f5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
